// File: rtl/ace_master_ctrl.sv
// ace_master_ctrl: ACE master-port controller between the cache datapath and
// the coherent interconnect.
//   Request engine issues ReadShared / WriteClean / MakeUnique with bursts of
//   BURST_LEN beats, re-issues on non-OKAY responses (up to MAX_RETRY times)
//   and aborts after TIMEOUT idle cycles in B_WAIT / R_DATA (0 disables).
//   Snoop engine (AC -> lookup -> CR/CD) runs concurrently and independently.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid, req_op, req_ready  datapath request handshake (op 11 is illegal)
//   read_shared_o/write_clean_o/make_unique_o  1-cycle pulse after accept
//   done_o, err_o                 completion pulse and its error qualifier
//   read_resp_en                  pulse the cycle after each OKAY ReadShared R beat
//   B_okay, R_okay                response status, sampled on B / R handshake
//   AW_*, W_*, B_*, AR_*, R_*     write/read request channels (VALID/READY/LAST)
//   AC_*, ac_enable, snoop_*      snoop address channel and datapath lookup
//   CR_*, CD_*                    snoop response and snoop data channels
// All outputs are registered: each is decoded from the next-state values.
module ace_master_ctrl #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned MAX_RETRY = 9,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       read_shared_o,
    output logic       write_clean_o,
    output logic       make_unique_o,
    output logic       done_o,
    output logic       err_o,
    output logic       read_resp_en,
    input  logic       B_okay,
    input  logic       R_okay,
    output logic       AW_VALID,
    input  logic       AW_READY,
    output logic       W_VALID,
    input  logic       W_READY,
    output logic       W_LAST,
    input  logic       B_VALID,
    output logic       B_READY,
    output logic       AR_VALID,
    input  logic       AR_READY,
    input  logic       R_VALID,
    output logic       R_READY,
    input  logic       R_LAST,
    input  logic       AC_VALID,
    output logic       AC_READY,
    output logic       ac_enable,
    input  logic       snoop_valid,
    input  logic       snoop_hit,
    input  logic       snoop_dirty,
    output logic       CR_VALID,
    input  logic       CR_READY,
    output logic       CD_VALID,
    input  logic       CD_READY,
    output logic       CD_LAST
);

    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] OP_RS = 2'b00;
    localparam logic [1:0] OP_WC = 2'b01;
    localparam logic [1:0] OP_MU = 2'b10;

    typedef enum logic [2:0] {IDLE, WR, B_WAIT, RD_ADDR, R_DATA, DONE} req_state_t;
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} snp_state_t;

    // Request engine state
    req_state_t     state, state_n;
    logic [1:0]     op_q, op_n;
    logic [RW-1:0]  retry_q, retry_n;
    logic [BW-1:0]  wbeat_q, wbeat_n;
    logic           aw_done_q, aw_done_n;
    logic           w_done_q, w_done_n;
    logic           fail_q, fail_n;
    logic [TW-1:0]  tmo_q, tmo_n;

    // Snoop engine state
    snp_state_t     s_state, s_state_n;
    logic           cr_done_q, cr_done_n;
    logic           cd_done_q, cd_done_n;
    logic [BW-1:0]  cdbeat_q, cdbeat_n;

    // Next values of the registered outputs
    logic req_ready_n, rs_n, wc_n, mu_n, done_n, err_n, rresp_n;
    logic aw_valid_n, w_valid_n, w_last_n, b_ready_n, ar_valid_n, r_ready_n;
    logic ac_ready_n, ac_enable_n, cr_valid_n, cd_valid_n, cd_last_n;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cr_hs, cd_hs;
    logic retry_ok, tmo_hit;

    assign aw_hs = AW_VALID & AW_READY;
    assign w_hs  = W_VALID & W_READY;
    assign b_hs  = B_VALID & B_READY;
    assign ar_hs = AR_VALID & AR_READY;
    assign r_hs  = R_VALID & R_READY;
    assign cr_hs = CR_VALID & CR_READY;
    assign cd_hs = CD_VALID & CD_READY;

    assign retry_ok = (retry_q < RW'(MAX_RETRY));
    // Fires on the cycle whose increment would make the counter reach TIMEOUT
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

    // Request engine: next state and next output values
    always_comb begin
        state_n   = state;
        op_n      = op_q;
        retry_n   = retry_q;
        wbeat_n   = wbeat_q;
        aw_done_n = aw_done_q;
        w_done_n  = w_done_q;
        fail_n    = fail_q;
        tmo_n     = tmo_q;
        rs_n      = 1'b0;
        wc_n      = 1'b0;
        mu_n      = 1'b0;
        err_n     = 1'b0;
        rresp_n   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_n      = req_op;
                    retry_n   = '0;
                    wbeat_n   = '0;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    fail_n    = 1'b0;
                    case (req_op)
                        OP_RS: begin rs_n = 1'b1; state_n = RD_ADDR; end
                        OP_WC: begin wc_n = 1'b1; state_n = WR;      end
                        OP_MU: begin mu_n = 1'b1; state_n = RD_ADDR; end
                        default: begin state_n = DONE; err_n = 1'b1; end
                    endcase
                end
            end

            // AW and W complete independently; both must finish before B
            WR: begin
                if (aw_hs) aw_done_n = 1'b1;
                if (w_hs) begin
                    if (W_LAST) w_done_n = 1'b1;
                    else        wbeat_n  = wbeat_q + BW'(1);
                end
                if (aw_done_n && w_done_n) begin
                    state_n = B_WAIT;
                    tmo_n   = '0;
                end
            end

            B_WAIT: begin
                if (b_hs) begin
                    if (B_okay) begin
                        state_n = DONE;
                    end else if (retry_ok) begin
                        retry_n   = retry_q + RW'(1);
                        wbeat_n   = '0;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = WR;
                    end else begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                end
            end

            RD_ADDR: begin
                if (ar_hs) begin
                    state_n = R_DATA;
                    tmo_n   = '0;
                end
            end

            // Failure is sticky across the burst and judged on the last beat
            R_DATA: begin
                if (r_hs) begin
                    tmo_n   = '0;
                    fail_n  = fail_q | ~R_okay;
                    rresp_n = (op_q == OP_RS) && R_okay;
                    if (R_LAST) begin
                        if (!fail_n) begin
                            state_n = DONE;
                        end else if (retry_ok) begin
                            retry_n = retry_q + RW'(1);
                            fail_n  = 1'b0;
                            state_n = RD_ADDR;
                        end else begin
                            state_n = DONE;
                            err_n   = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                end
            end

            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        req_ready_n = (state_n == IDLE);
        done_n      = (state_n == DONE);
        aw_valid_n  = (state_n == WR) && !aw_done_n;
        w_valid_n   = (state_n == WR) && !w_done_n;
        w_last_n    = w_valid_n && (wbeat_n == BW'(BURST_LEN - 1));
        b_ready_n   = (state_n == B_WAIT);
        ar_valid_n  = (state_n == RD_ADDR);
        r_ready_n   = (state_n == R_DATA);
    end

    // Snoop engine: next state and next output values
    always_comb begin
        s_state_n = s_state;
        cr_done_n = cr_done_q;
        cd_done_n = cd_done_q;
        cdbeat_n  = cdbeat_q;

        case (s_state)
            S_IDLE: begin
                if (AC_VALID && AC_READY) s_state_n = S_LOOKUP;
            end

            // Data is returned only for a dirty hit; otherwise CD is pre-completed
            S_LOOKUP: begin
                if (snoop_valid) begin
                    cr_done_n = 1'b0;
                    cd_done_n = !(snoop_hit && snoop_dirty);
                    cdbeat_n  = '0;
                    s_state_n = S_RESP;
                end
            end

            S_RESP: begin
                if (cr_hs) cr_done_n = 1'b1;
                if (cd_hs) begin
                    if (CD_LAST) cd_done_n = 1'b1;
                    else         cdbeat_n  = cdbeat_q + BW'(1);
                end
                if (cr_done_n && cd_done_n) s_state_n = S_IDLE;
            end

            default: s_state_n = S_IDLE;
        endcase

        ac_ready_n  = (s_state_n == S_IDLE);
        ac_enable_n = (s_state_n == S_LOOKUP);
        cr_valid_n  = (s_state_n == S_RESP) && !cr_done_n;
        cd_valid_n  = (s_state_n == S_RESP) && !cd_done_n;
        cd_last_n   = cd_valid_n && (cdbeat_n == BW'(BURST_LEN - 1));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= 2'b00;
            retry_q       <= '0;
            wbeat_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            fail_q        <= 1'b0;
            tmo_q         <= '0;
            s_state       <= S_IDLE;
            cr_done_q     <= 1'b0;
            cd_done_q     <= 1'b0;
            cdbeat_q      <= '0;
            req_ready     <= 1'b0;
            read_shared_o <= 1'b0;
            write_clean_o <= 1'b0;
            make_unique_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            read_resp_en  <= 1'b0;
            AW_VALID      <= 1'b0;
            W_VALID       <= 1'b0;
            W_LAST        <= 1'b0;
            B_READY       <= 1'b0;
            AR_VALID      <= 1'b0;
            R_READY       <= 1'b0;
            AC_READY      <= 1'b0;
            ac_enable     <= 1'b0;
            CR_VALID      <= 1'b0;
            CD_VALID      <= 1'b0;
            CD_LAST       <= 1'b0;
        end else begin
            state         <= state_n;
            op_q          <= op_n;
            retry_q       <= retry_n;
            wbeat_q       <= wbeat_n;
            aw_done_q     <= aw_done_n;
            w_done_q      <= w_done_n;
            fail_q        <= fail_n;
            tmo_q         <= tmo_n;
            s_state       <= s_state_n;
            cr_done_q     <= cr_done_n;
            cd_done_q     <= cd_done_n;
            cdbeat_q      <= cdbeat_n;
            req_ready     <= req_ready_n;
            read_shared_o <= rs_n;
            write_clean_o <= wc_n;
            make_unique_o <= mu_n;
            done_o        <= done_n;
            err_o         <= err_n;
            read_resp_en  <= rresp_n;
            AW_VALID      <= aw_valid_n;
            W_VALID       <= w_valid_n;
            W_LAST        <= w_last_n;
            B_READY       <= b_ready_n;
            AR_VALID      <= ar_valid_n;
            R_READY       <= r_ready_n;
            AC_READY      <= ac_ready_n;
            ac_enable     <= ac_enable_n;
            CR_VALID      <= cr_valid_n;
            CD_VALID      <= cd_valid_n;
            CD_LAST       <= cd_last_n;
        end
    end

endmodule

// File: tb/tb_ace_master_ctrl.sv
// Scoreboard bench for ace_master_ctrl: expected request/snoop outcomes are
// queued when stimulus is issued and compared when done_o / snoop completion
// is observed. Interconnect and datapath are modelled by a responder process.
module tb_ace_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready, read_shared_o, write_clean_o, make_unique_o;
    logic       done_o, err_o, read_resp_en;
    logic       B_okay, R_okay;
    logic       AW_VALID, AW_READY, W_VALID, W_READY, W_LAST;
    logic       B_VALID, B_READY, AR_VALID, AR_READY;
    logic       R_VALID, R_READY, R_LAST;
    logic       AC_VALID, AC_READY, ac_enable;
    logic       snoop_valid, snoop_hit, snoop_dirty;
    logic       CR_VALID, CR_READY, CD_VALID, CD_READY, CD_LAST;

    always #5 clk = ~clk;

    ace_master_ctrl #(.BURST_LEN(4), .MAX_RETRY(9), .TIMEOUT(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .read_shared_o(read_shared_o), .write_clean_o(write_clean_o),
        .make_unique_o(make_unique_o), .done_o(done_o), .err_o(err_o),
        .read_resp_en(read_resp_en), .B_okay(B_okay), .R_okay(R_okay),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST),
        .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_LAST(R_LAST),
        .AC_VALID(AC_VALID), .AC_READY(AC_READY), .ac_enable(ac_enable),
        .snoop_valid(snoop_valid), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .CR_VALID(CR_VALID), .CR_READY(CR_READY),
        .CD_VALID(CD_VALID), .CD_READY(CD_READY), .CD_LAST(CD_LAST)
    );

    // -1 in a field means "not compared for this request"
    typedef struct {
        int err; int aw; int w; int wlast; int ar; int rresp;
        int pulse; int first_bus; int done_lat; int tmo_lat;
    } req_exp_t;
    typedef struct { int cr; int cd; int cdlast; } snp_exp_t;

    req_exp_t req_q[$];
    snp_exp_t snp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Responder configuration
    int cur_len = 4;
    bit r_fail_first = 0;
    int cr_stall = 0;
    bit cfg_hit = 0;
    bit cfg_dirty = 0;

    // Responder state
    int rbeat = 0, rburst = 0, cr_cnt = 0;

    // Monitor state
    int cyc = 0, acc_cyc = 0, rdata_cyc = 0, wbeat = 0;
    int m_aw, m_w, m_wlast, m_ar, m_rresp, m_pulse, m_first;
    bit r_ready_prev = 0;
    bit snp_act = 0;
    int s_cr = 0, s_cd = 0, s_cdlast = 0;

    logic [17:0] outs;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample_outs();
        outs = {req_ready, read_shared_o, write_clean_o, make_unique_o, done_o, err_o,
                read_resp_en, AW_VALID, W_VALID, W_LAST, B_READY, AR_VALID, R_READY,
                AC_READY, ac_enable, CR_VALID, CD_VALID, CD_LAST};
    endtask

    task automatic clear_req_counters();
        m_aw = 0; m_w = 0; m_wlast = 0; m_ar = 0; m_rresp = 0; m_pulse = 0;
        m_first = -1; wbeat = 0;
    endtask

    // Interconnect / datapath model: samples at negedge, drives after posedge
    task automatic responder();
        bit c_rst, c_idle, c_rhs, c_rlast, c_crv, c_crhs, c_acen;
        forever begin
            @(negedge clk);
            c_rst = rst; c_idle = req_ready;
            c_rhs = R_VALID && R_READY; c_rlast = R_LAST;
            c_crv = CR_VALID; c_crhs = CR_VALID && CR_READY; c_acen = ac_enable;
            @(posedge clk);
            #1;
            if (c_rst || c_idle) begin
                rbeat = 0; rburst = 0;
            end else if (c_rhs) begin
                if (c_rlast) begin rbeat = 0; rburst++; end
                else rbeat++;
            end
            if (c_rst || c_crhs) cr_cnt = 0;
            else if (c_crv) cr_cnt++;
            R_LAST      = (rbeat == cur_len - 1);
            R_okay      = !(r_fail_first && rburst == 0 && rbeat == 1);
            CR_READY    = (cr_cnt >= cr_stall);
            snoop_valid = c_acen && !c_rst;
            snoop_hit   = cfg_hit;
            snoop_dirty = cfg_dirty;
        end
    endtask

    // Observes the DUT at negedge, accumulates per-transaction counts, scores
    task automatic monitor();
        req_exp_t e;
        snp_exp_t s;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                clear_req_counters();
                r_ready_prev = 0;
                snp_act = 0;
            end else begin
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    clear_req_counters();
                end
                if ((AW_VALID || AR_VALID) && m_first < 0) m_first = cyc - acc_cyc;
                if (AW_VALID && AW_READY) m_aw++;
                if (W_VALID && W_READY) begin
                    m_w++; wbeat++;
                    if (W_LAST) begin m_wlast = wbeat; wbeat = 0; end
                end
                // a late pulse from the previous burst is counted before AR restarts the tally
                if (read_resp_en) m_rresp++;
                if (AR_VALID && AR_READY) begin m_ar++; m_rresp = 0; end
                m_pulse += int'(read_shared_o) + int'(write_clean_o) + int'(make_unique_o);
                if (R_READY && !r_ready_prev) rdata_cyc = cyc;
                r_ready_prev = R_READY;

                if (done_o) begin
                    check("done_expected", int'(req_q.size() > 0), 1);
                    if (req_q.size() > 0) begin
                        e = req_q.pop_front();
                        check("err_o", int'(err_o), e.err);
                        check("aw_handshakes", m_aw, e.aw);
                        check("w_beats", m_w, e.w);
                        check("w_last_beat", m_wlast, e.wlast);
                        check("ar_handshakes", m_ar, e.ar);
                        check("read_resp_en", m_rresp, e.rresp);
                        check("op_pulses", m_pulse, e.pulse);
                        check("first_bus_cycle", m_first, e.first_bus);
                        if (e.done_lat >= 0) check("done_latency", cyc - acc_cyc, e.done_lat);
                        if (e.tmo_lat >= 0) check("timeout_latency", cyc - rdata_cyc, e.tmo_lat);
                    end
                end

                if (snp_act && AC_READY) begin
                    check("snoop_expected", int'(snp_q.size() > 0), 1);
                    if (snp_q.size() > 0) begin
                        s = snp_q.pop_front();
                        check("cr_valid_cycles", s_cr, s.cr);
                        check("cd_beats", s_cd, s.cd);
                        check("cd_last_beat", s_cdlast, s.cdlast);
                    end
                    snp_act = 0;
                end
                if (AC_VALID && AC_READY) begin
                    snp_act = 1; s_cr = 0; s_cd = 0; s_cdlast = 0;
                end
                if (CR_VALID) s_cr++;
                if (CD_VALID && CD_READY) begin
                    s_cd++;
                    if (CD_LAST) s_cdlast = s_cd;
                end
            end
        end
    endtask

    task automatic do_req(input logic [1:0] op);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check("req_accept", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
    endtask

    task automatic send_ac();
        int n = 0;
        AC_VALID = 1'b1;
        @(negedge clk);
        while (!AC_READY && n < 100) begin @(negedge clk); n++; end
        check("ac_accept", int'(AC_READY), 1);
        @(posedge clk);
        #1;
        AC_VALID = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((req_q.size() != 0 || snp_q.size() != 0) && n < budget) begin
            @(posedge clk); n++;
        end
        check("drain_req_q", req_q.size(), 0);
        check("drain_snp_q", snp_q.size(), 0);
        req_q.delete();
        snp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic req_exp_t mk(input int err, input int aw, input int w, input int wlast,
                                    input int ar, input int rresp, input int pulse,
                                    input int first_bus, input int done_lat, input int tmo_lat);
        req_exp_t e;
        e.err = err; e.aw = aw; e.w = w; e.wlast = wlast; e.ar = ar; e.rresp = rresp;
        e.pulse = pulse; e.first_bus = first_bus; e.done_lat = done_lat; e.tmo_lat = tmo_lat;
        return e;
    endfunction

    function automatic snp_exp_t mks(input int cr, input int cd, input int cdlast);
        snp_exp_t s;
        s.cr = cr; s.cd = cd; s.cdlast = cdlast;
        return s;
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        B_okay = 1'b1; R_okay = 1'b1;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; AR_READY = 1'b1;
        R_VALID = 1'b1; R_LAST = 1'b0; AC_VALID = 1'b0;
        snoop_valid = 1'b0; snoop_hit = 1'b0; snoop_dirty = 1'b0;
        CR_READY = 1'b1; CD_READY = 1'b1;
        clear_req_counters();

        fork
            responder();
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        sample_outs();
        check("reset_outputs", int'(outs), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", int'(req_ready), 1);
        check("ac_ready_after_reset", int'(AC_READY), 1);

        // WriteClean, everything ready, OKAY
        req_q.push_back(mk(0, 1, 4, 4, 0, 0, 1, 1, -1, -1));
        do_req(2'b01);
        drain(500);

        // ReadShared, beat 2 of the first burst non-OKAY -> one re-issue
        cur_len = 4; r_fail_first = 1;
        req_q.push_back(mk(0, 0, 0, 0, 2, 4, 1, 1, -1, -1));
        do_req(2'b00);
        drain(500);
        r_fail_first = 0;

        // MakeUnique, single-beat read, never raises read_resp_en
        cur_len = 1;
        req_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, -1, -1));
        do_req(2'b10);
        drain(500);
        cur_len = 4;

        // WriteClean, B never OKAY -> 10 attempts then error
        B_okay = 1'b0;
        req_q.push_back(mk(1, 10, 40, 4, 0, 0, 1, 1, -1, -1));
        do_req(2'b01);
        drain(1000);
        B_okay = 1'b1;

        // ReadShared, no R beats -> timeout 256 cycles after entering R_DATA
        R_VALID = 1'b0;
        req_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, -1, 256));
        do_req(2'b00);
        drain(2000);
        R_VALID = 1'b1;

        // Illegal op: done+err in cycle 1, no bus traffic
        req_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, -1, 1, -1));
        do_req(2'b11);
        drain(500);

        // Dirty snoop hit alongside a write, CR stalled for 5 cycles
        cr_stall = 5; cfg_hit = 1; cfg_dirty = 1;
        req_q.push_back(mk(0, 1, 4, 4, 0, 0, 1, 1, -1, -1));
        snp_q.push_back(mks(6, 4, 4));
        fork
            do_req(2'b01);
            send_ac();
        join
        drain(500);

        // Snoop miss: response only, no data
        cr_stall = 0; cfg_hit = 0; cfg_dirty = 0;
        snp_q.push_back(mks(1, 0, 0));
        send_ac();
        drain(500);

        // Reset in the middle of R_DATA: abandoned, outputs cleared, no done_o
        R_VALID = 1'b0;
        do_req(2'b00);
        begin
            int n = 0;
            @(negedge clk);
            while (!R_READY && n < 100) begin @(negedge clk); n++; end
            check("reached_r_data", int'(R_READY), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sample_outs();
        check("mid_reset_outputs", int'(outs), 0);
        rst = 1'b0;
        R_VALID = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_mid_reset", int'(req_ready), 1);
        check("ac_ready_after_mid_reset", int'(AC_READY), 1);
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
